// File: rtl/ab_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ab_pkg
// Brief   : Shared widths, default FIFO depth and dispatcher FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package ab_pkg;

    localparam int c_op_w          = 8;
    localparam int c_res_w         = 16;
    localparam int c_depth_default = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } ab_state_t;

endpackage
`default_nettype wire

// File: rtl/ab_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ab_fifo
// Brief   : Circular-buffer FIFO with occupancy count; no write-to-read bypass.
// Revision: 1.0 - initial release
// ============================================================================
module ab_fifo
    import ab_pkg::*;
#(
    parameter int DEPTH = c_depth_default,
    parameter int WIDTH = 2 * c_op_w
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_full_cnt = DEPTH[c_ptr_w:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ab_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : ab_dispatch
// Brief   : Queues operand pairs and issues them one at a time to an ab unit,
//           capturing each result into a handshaked output register.
// Revision: 1.0 - initial release
// ============================================================================
module ab_dispatch
    import ab_pkg::*;
#(
    parameter int DEPTH = c_depth_default
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [c_op_w-1:0]  a_i,
    input  logic [c_op_w-1:0]  b_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [c_op_w-1:0]  ab_a_o,
    output logic [c_op_w-1:0]  ab_b_o,
    output logic               ab_start_o,
    input  logic               ab_busy_i,
    input  logic [c_res_w-1:0] ab_y_i,
    output logic [c_res_w-1:0] y_o,
    output logic               y_valid_o,
    input  logic               y_ready_i,
    output logic [7:0]         done_cnt_o
);

    ab_state_t             r_state;
    ab_state_t             w_next_state;
    logic                  w_issue;
    logic                  w_capture;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [2*c_op_w-1:0]   w_head;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                  w_unused;
    logic [c_op_w-1:0]     r_ab_a;
    logic [c_op_w-1:0]     r_ab_b;
    logic [c_res_w-1:0]    r_y;
    logic                  r_y_valid;
    logic [7:0]            r_done_cnt;

    ab_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * c_op_w)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (valid_i),
        .i_pop   (w_issue),
        .i_din   ({a_i, b_i}),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_unused   = ^w_fifo_count;
    assign ready_o    = !w_fifo_full;
    assign ab_start_o = (r_state == ST_ISSUE);
    assign ab_a_o     = r_ab_a;
    assign ab_b_o     = r_ab_b;
    assign y_o        = r_y;
    assign y_valid_o  = r_y_valid;
    assign done_cnt_o = r_done_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Issue only once the output register is empty or draining this edge,
    // so a capture can never collide with an unconsumed result.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !ab_busy_i && (!r_y_valid || y_ready_i)) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ab_busy_i) begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!ab_busy_i) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ab_a     <= '0;
            r_ab_b     <= '0;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_issue) begin
                {r_ab_a, r_ab_b} <= w_head;
            end
            if (w_capture) begin
                r_y        <= ab_y_i;
                r_y_valid  <= 1'b1;
                r_done_cnt <= r_done_cnt + 8'd1;
            end else if (r_y_valid && y_ready_i) begin
                r_y_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
